// File: rtl/fifo_uart_tx_if.sv
// Bus between the FIFO read port and the serial drain stage, plus serial-side status.
// Pop handshake: read_from_stack is a one-cycle pop strobe, only raised while stack_empty was low; Data_out is valid the cycle after it.
interface fifo_uart_tx_if;
    logic       enable;
    logic       stack_empty;
    logic       read_from_stack;
    logic [7:0] Data_out;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [2:0] dbg_state;

    modport master (
        output enable, stack_empty, Data_out,
        input  read_from_stack, tx, busy, tx_done, dbg_state
    );

    modport slave (
        input  enable, stack_empty, Data_out,
        output read_from_stack, tx, busy, tx_done, dbg_state
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and serialises each byte as an async frame:
// start, 8 data bits LSB first, optional even parity, stop bits. Every output is registered.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.slave  io_fifo
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    localparam int            BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_tx;
    logic          r_rd;
    logic          r_busy;
    logic          r_done;

    logic [2:0]    w_state_next;
    logic [BW-1:0] w_baud_next;
    logic [2:0]    w_bit_next;
    logic [7:0]    w_shift_next;
    logic          w_parity_next;
    logic          w_tx_next;
    logic          w_done_next;
    logic          w_baud_last;
    logic          w_can_pop;
    logic          w_timed;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_can_pop   = io_fifo.enable && !io_fifo.stack_empty;
    assign w_timed     = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) w_state_next = S_POP;
            end
            S_POP: begin
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                w_state_next  = S_START;
                w_shift_next  = io_fifo.Data_out;
                w_parity_next = ^io_fifo.Data_out;
            end
            S_START: begin
                if (w_baud_last) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_next = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_baud_last) w_state_next = S_STOP;
            end
            S_STOP: begin
                // The final stop cycle doubles as the IDLE check so frames can run back-to-back.
                if (w_baud_last && (r_bit == STOP_LAST)) w_state_next = w_can_pop ? S_POP : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud and bit counters restart on every state change; the bit counter also counts stop bits.
    always_comb begin
        w_baud_next = '0;
        w_bit_next  = '0;
        if ((w_state_next == r_state) && w_timed) begin
            w_baud_next = w_baud_last ? '0 : r_baud + BW'(1);
            w_bit_next  = w_baud_last ? r_bit + 3'd1 : r_bit;
        end
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign w_done_next = (w_state_next == S_STOP) && (w_baud_next == BAUD_LAST) &&
                         (w_bit_next == STOP_LAST);

    // Outputs are loaded from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_rd     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_rd     <= (w_state_next == S_POP);
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= w_done_next;
        end
    end

    assign io_fifo.tx              = r_tx;
    assign io_fifo.read_from_stack = r_rd;
    assign io_fifo.busy            = r_busy;
    assign io_fifo.tx_done         = r_done;
    assign io_fifo.dbg_state       = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds two instances (no parity / even parity) and a
// serial monitor decodes frames against an expected-byte queue.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_uart_tx_if if0();
    fifo_uart_tx_if if1();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .io_fifo(if0)
    );
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .io_fifo(if1)
    );

    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] dout = 8'h00;
    logic [7:0] fifo_mem [0:31];
    int         n_pushed = 0;
    int         n_popped = 0;
    logic       empty;
    logic [7:0] exp_q [$];

    assign empty          = (n_pushed == n_popped);
    assign if0.enable      = en0;
    assign if1.enable      = en1;
    assign if0.stack_empty = empty;
    assign if1.stack_empty = empty;
    assign if0.Data_out    = dout;
    assign if1.Data_out    = dout;

    logic mon_tx, mon_busy, mon_done, rd_any;
    assign mon_tx   = sel ? if1.tx      : if0.tx;
    assign mon_busy = sel ? if1.busy    : if0.busy;
    assign mon_done = sel ? if1.tx_done : if0.tx_done;
    assign rd_any   = if0.read_from_stack | if1.read_from_stack;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int rst_edges = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_edges <= rst_edges + 1;
    end

    int strobe_t [0:31];
    int n_strobes = 0;
    always @(negedge clk) begin
        if (rd_any === 1'b1) begin
            strobe_t[n_strobes] = cyc;
            n_strobes++;
            dout = fifo_mem[n_popped];
            n_popped++;
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (mon_done === 1'b1) done_cnt++;

    int   start_t [0:15];
    int   end_t   [0:15];
    logic par_log [0:15];
    int   n_frames  = 0;
    int   n_aborted = 0;

    initial begin : monitor
        logic [7:0] got;
        logic [7:0] e;
        logic       gpar;
        logic       bad;
        logic       par_on;
        int         rst0;
        int         s_cyc;
        forever begin
            @(negedge clk);
            if (mon_tx === 1'b0) begin
                rst0   = rst_edges;
                s_cyc  = cyc;
                par_on = sel;
                got    = 8'h00;
                gpar   = 1'b0;
                bad    = 1'b0;
                for (int c = 1; c < CPB; c++) begin
                    @(negedge clk);
                    if (mon_tx !== 1'b0 || mon_done !== 1'b0 || mon_busy !== 1'b1) bad = 1'b1;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (c == 0) got[b] = mon_tx;
                        else if (mon_tx !== got[b]) bad = 1'b1;
                        if (mon_done !== 1'b0 || mon_busy !== 1'b1) bad = 1'b1;
                    end
                end
                if (par_on) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (c == 0) gpar = mon_tx;
                        else if (mon_tx !== gpar) bad = 1'b1;
                        if (mon_done !== 1'b0) bad = 1'b1;
                    end
                end
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    if (mon_tx !== 1'b1 || mon_busy !== 1'b1) bad = 1'b1;
                    if (mon_done !== ((c == CPB - 1) ? 1'b1 : 1'b0)) bad = 1'b1;
                end
                start_t[n_frames] = s_cyc;
                end_t[n_frames]   = cyc;
                par_log[n_frames] = gpar;
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_frame", 32'd1, 32'd0);
                end else if (rst_edges != rst0) begin
                    e = exp_q.pop_front();
                    n_aborted++;
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", {24'h0, got}, {24'h0, e});
                    if (par_on) check("rx_parity", {31'h0, gpar}, {31'h0, ^e});
                    check("frame_shape", {31'h0, bad}, 32'd0);
                end
                n_frames++;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[n_pushed] = b;
        exp_q.push_back(b);
        n_pushed++;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (n_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_frames", {31'h0, n_frames >= target}, 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (n_strobes < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_strobes", {31'h0, n_strobes >= target}, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rst_fall;
        int tgt;
        logic bad;

        // Reset with data available and enable high: outputs must stay quiet.
        rst = 1'b1;
        en0 = 1'b1;
        push_byte(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {28'h0, if0.tx, if0.read_from_stack, if0.busy, if0.tx_done}, 32'h8);
        end
        check("reset_state", {29'h0, if0.dbg_state}, 32'd0);
        check("reset_state_par", {29'h0, if1.dbg_state}, 32'd0);
        rst      = 1'b0;
        rst_fall = cyc;

        // Single byte, then empty.
        wait_frames(1, 200);
        check("first_strobe_lat", strobe_t[0] - rst_fall, 32'd1);
        check("frame_len_noparity", end_t[0] - start_t[0] + 1, 32'd40);
        repeat (10) @(negedge clk);
        check("single_strobe", n_strobes, 32'd1);
        check("single_done", done_cnt, 32'd1);
        check("idle_after_frame", {30'h0, if0.busy, if0.tx}, 32'd1);

        // Back-to-back bytes, enable dropped during the second frame.
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_strobes(3, 200);
        check("b2b_strobe_gap", strobe_t[2] - strobe_t[1], 32'd42);
        repeat (10) @(negedge clk);
        en0 = 1'b0;
        push_byte(8'h3C);
        wait_frames(3, 200);
        repeat (60) @(negedge clk);
        check("b2b_idle_cycles", start_t[2] - end_t[1] - 1, 32'd2);
        check("no_pop_after_disable", n_strobes, 32'd3);
        check("busy_after_disable", {31'h0, if0.busy}, 32'd0);

        // Re-enable to drain the byte left behind.
        en0 = 1'b1;
        wait_frames(4, 200);
        en0 = 1'b0;

        // Even-parity instance.
        repeat (5) @(negedge clk);
        sel = 1'b1;
        en1 = 1'b1;
        push_byte(8'h07);
        push_byte(8'h03);
        wait_frames(6, 300);
        en1 = 1'b0;
        check("parity_07", {31'h0, par_log[4]}, 32'd1);
        check("parity_03", {31'h0, par_log[5]}, 32'd0);
        check("frame_len_parity", end_t[4] - start_t[4] + 1, 32'd44);
        check("parity_strobe_gap", strobe_t[5] - strobe_t[4], 32'd46);
        repeat (5) @(negedge clk);
        sel = 1'b0;

        // Empty FIFO with enable high.
        en0 = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.read_from_stack !== 1'b0) bad = 1'b1;
        end
        check("empty_idle", {31'h0, bad}, 32'd0);
        check("empty_no_strobe", n_strobes, 32'd6);

        // Reset in the middle of data bit 3 of 0x55.
        push_byte(8'h55);
        wait_strobes(7, 50);
        tgt = strobe_t[6] + 2 + CPB + 3 * CPB + 1;
        while (cyc < tgt) @(negedge clk);
        check("data_bit3", {31'h0, if0.tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {30'h0, if0.tx, if0.busy}, 32'd2);
        check("abort_state", {29'h0, if0.dbg_state}, 32'd0);
        repeat (60) @(negedge clk);
        check("abort_no_retry", n_strobes, 32'd7);
        check("abort_seen", n_aborted, 32'd1);

        // Next frame after the abort starts from IDLE.
        push_byte(8'h5A);
        wait_frames(8, 200);
        check("post_abort_strobes", n_strobes, 32'd8);
        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
